// File: rtl/eth_pkg.sv
// Shared constants, state encoding and frame-geometry helper for the local frame builder.
package eth_pkg;

   localparam int unsigned ETH_HDR_BYTES   = 14;
   localparam int unsigned ETH_MIN_PAYLOAD = 46;
   localparam int unsigned ETH_MAX_PAYLOAD = 1500;

   localparam int unsigned LEN_W  = 11;
   localparam int unsigned WCNT_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned MOD_W  = 2;
   localparam int unsigned MAC_W  = 48;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      SPLICE,
      BODY,
      PAD,
      DONE
   } eth_state_e;

   typedef struct packed {
      logic [WCNT_W-1:0] words;
      logic [MOD_W-1:0]  mod;
   } frame_geom_t;

   // Word count and EOP empty-byte count for a frame of 'total' bytes.
   function automatic frame_geom_t frame_geom(input logic [LEN_W-1:0] total);
      frame_geom_t g;
      logic [LEN_W:0] rounded;
      rounded = {1'b0, total} + (LEN_W+1)'(3);
      g.words = WCNT_W'(rounded >> 2);
      g.mod   = ~total[1:0] + 2'd1;
      return g;
   endfunction

endpackage

// File: rtl/eth_tx_align.sv
// Half-word realignment: carries the low half of each payload word into the next frame word.
module eth_tx_align
   import eth_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              adv,
   input  logic              use_pl,
   input  logic              splice,
   input  logic [HALF_W-1:0] ethertype,
   input  logic [DATA_W-1:0] pl_word,
   output logic [DATA_W-1:0] body_word
);

   logic [HALF_W-1:0] hold;

   // Hold empties to zero on any word that does not consume payload, feeding the pad.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
      end else if (clear) begin
         hold <= '0;
      end else if (adv) begin
         hold <= use_pl ? pl_word[HALF_W-1:0] : '0;
      end
   end

   always_comb begin
      body_word = '0;
      body_word[DATA_W-1:HALF_W] = splice ? ethertype : hold;
      body_word[HALF_W-1:0]      = use_pl ? pl_word[DATA_W-1:HALF_W] : '0;
   end

endmodule

// File: rtl/eth_frame_tx.sv
// Builds header + payload + zero-pad Ethernet frames as a 32-bit SOP/EOP/mod word stream.
module eth_frame_tx
   import eth_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [MAC_W-1:0]  i_dst_mac,
   input  logic [MAC_W-1:0]  i_src_mac,
   input  logic [HALF_W-1:0] i_ethertype,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [DATA_W-1:0] i_pl_data,
   input  logic              i_pl_vld,
   output logic              o_pl_rdy,
   output logic [DATA_W-1:0] o_tx_data,
   output logic [MOD_W-1:0]  o_tx_mod,
   output logic              o_tx_sop,
   output logic              o_tx_eop,
   output logic              o_tx_vld,
   input  logic              i_tx_rdy,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   eth_state_e        state;
   logic [MAC_W-1:0]  dst;
   logic [MAC_W-1:0]  src;
   logic [HALF_W-1:0] etype;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] last_w;
   logic [WCNT_W-1:0] pl_left;
   logic [MOD_W-1:0]  eop_mod;
   logic [2:0]        last_bytes;
   logic              err_q;

   logic              active;
   logic              need_pl;
   logic              avail;
   logic              xfer;
   logic              is_last;
   logic [LEN_W-1:0]  total;
   frame_geom_t       geom;
   logic [DATA_W-1:0] pl_masked;
   logic [DATA_W-1:0] body_word;

   assign active  = (state == HDR) || (state == SPLICE) || (state == BODY) || (state == PAD);
   assign need_pl = ((state == SPLICE) || (state == BODY)) && (pl_left != '0);
   assign avail   = active && (!need_pl || i_pl_vld);
   assign xfer    = avail && i_tx_rdy;
   assign is_last = (wcnt == last_w);

   assign o_tx_vld = xfer;
   assign o_pl_rdy = need_pl && i_tx_rdy;
   assign o_tx_sop = xfer && (state == HDR) && (wcnt == '0);
   assign o_tx_eop = xfer && is_last;
   assign o_tx_mod = o_tx_eop ? eop_mod : '0;
   assign o_busy   = (state != IDLE);
   assign o_done   = (state == DONE);
   assign o_err    = err_q;

   always_comb begin
      total = LEN_W'(ETH_HDR_BYTES) +
              ((i_len < LEN_W'(ETH_MIN_PAYLOAD)) ? LEN_W'(ETH_MIN_PAYLOAD) : i_len);
      geom  = frame_geom(total);
   end

   // Bytes past i_len in the final payload word become zero, merging into the pad.
   always_comb begin
      pl_masked = i_pl_data;
      if (pl_left == WCNT_W'(1)) begin
         for (int i = 1; i < 4; i++) begin
            if (3'(i) >= last_bytes) pl_masked[DATA_W-1-8*i -: 8] = 8'h00;
         end
      end
   end

   always_comb begin
      o_tx_data = '0;
      case (state)
         HDR: begin
            case (wcnt[1:0])
               2'd0:    o_tx_data = dst[47:16];
               2'd1:    o_tx_data = {dst[15:0], src[47:32]};
               default: o_tx_data = src[31:0];
            endcase
         end
         SPLICE, BODY, PAD: o_tx_data = body_word;
         default:           o_tx_data = '0;
      endcase
   end

   eth_tx_align u_align (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == IDLE),
      .adv       (xfer),
      .use_pl    (need_pl),
      .splice    (state == SPLICE),
      .ethertype (etype),
      .pl_word   (pl_masked),
      .body_word (body_word)
   );

   // Frame sequencer: latches the request, walks header/splice/body/pad, one word per transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dst        <= '0;
         src        <= '0;
         etype      <= '0;
         wcnt       <= '0;
         last_w     <= '0;
         pl_left    <= '0;
         eop_mod    <= '0;
         last_bytes <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  if (i_len <= LEN_W'(ETH_MAX_PAYLOAD)) begin
                     dst        <= i_dst_mac;
                     src        <= i_src_mac;
                     etype      <= i_ethertype;
                     wcnt       <= '0;
                     last_w     <= geom.words - WCNT_W'(1);
                     eop_mod    <= geom.mod;
                     pl_left    <= WCNT_W'((i_len + LEN_W'(3)) >> 2);
                     last_bytes <= (i_len[1:0] == 2'd0) ? 3'd4 : {1'b0, i_len[1:0]};
                     state      <= HDR;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            HDR: begin
               if (xfer) begin
                  wcnt <= wcnt + WCNT_W'(1);
                  if (wcnt == WCNT_W'(2)) state <= SPLICE;
               end
            end
            SPLICE, BODY, PAD: begin
               if (xfer) begin
                  wcnt <= wcnt + WCNT_W'(1);
                  if (need_pl) pl_left <= pl_left - WCNT_W'(1);
                  if (is_last) state <= DONE;
                  else if (need_pl && (pl_left != WCNT_W'(1))) state <= BODY;
                  else state <= PAD;
               end
            end
            DONE: begin
               wcnt  <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: frame contents, geometry, stalls, rejection, busy-start and reset abort.
module tb_eth_frame_tx;

   localparam logic [47:0] DST  = 48'h0011_2233_4455;
   localparam logic [47:0] SRC  = 48'h6677_8899_AABB;
   localparam logic [15:0] TYPE = 16'h88B5;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [47:0] i_dst_mac;
   logic [47:0] i_src_mac;
   logic [15:0] i_ethertype;
   logic [10:0] i_len;
   logic [31:0] i_pl_data;
   logic        i_pl_vld;
   logic        o_pl_rdy;
   logic [31:0] o_tx_data;
   logic [1:0]  o_tx_mod;
   logic        o_tx_sop;
   logic        o_tx_eop;
   logic        o_tx_vld;
   logic        i_tx_rdy;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   int vectors;
   int miscompares;

   logic [31:0] cap [0:511];
   int          cap_n, sop_cnt, sop_idx, eop_cnt, eop_idx, pl_taken, vld_bad, mod_bad;
   int          done_at, err_seen, first_bad;
   logic [1:0]  eop_mod;

   eth_frame_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_dst_mac   (i_dst_mac),
      .i_src_mac   (i_src_mac),
      .i_ethertype (i_ethertype),
      .i_len       (i_len),
      .i_pl_data   (i_pl_data),
      .i_pl_vld    (i_pl_vld),
      .o_pl_rdy    (o_pl_rdy),
      .o_tx_data   (o_tx_data),
      .o_tx_mod    (o_tx_mod),
      .o_tx_sop    (o_tx_sop),
      .o_tx_eop    (o_tx_eop),
      .o_tx_vld    (o_tx_vld),
      .i_tx_rdy    (i_tx_rdy),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source payload byte; bytes past len are junk the DUT must discard.
   function automatic logic [7:0] src_byte(input int p, input int seed, input int len);
      return (p < len) ? 8'(seed + p) : 8'hEE;
   endfunction

   function automatic logic [31:0] src_word(input int m, input int seed, input int len);
      return {src_byte(4*m, seed, len), src_byte(4*m+1, seed, len),
              src_byte(4*m+2, seed, len), src_byte(4*m+3, seed, len)};
   endfunction

   function automatic logic [7:0] exp_byte(input int b, input int seed, input int len);
      if (b < 6)        return 8'(DST >> (8*(5-b)));
      if (b < 12)       return 8'(SRC >> (8*(11-b)));
      if (b < 14)       return 8'(TYPE >> (8*(13-b)));
      if (b < 14 + len) return 8'(seed + b - 14);
      return 8'h00;
   endfunction

   function automatic logic [31:0] exp_word(input int k, input int seed, input int len);
      return {exp_byte(4*k, seed, len), exp_byte(4*k+1, seed, len),
              exp_byte(4*k+2, seed, len), exp_byte(4*k+3, seed, len)};
   endfunction

   // Number of captured words differing from the model; first_bad records the earliest.
   function automatic int count_bad(input int seed, input int len);
      int n;
      n = 0;
      first_bad = -1;
      for (int k = 0; k < cap_n; k++) begin
         if (cap[k] !== exp_word(k, seed, len)) begin
            if (n == 0) first_bad = k;
            n++;
         end
      end
      return n;
   endfunction

   task automatic run_frame(input int len, input int seed, input bit stall,
                            input int restart_at, input int stop_words, input int max_cyc);
      int pidx;
      cap_n = 0; sop_cnt = 0; sop_idx = -1; eop_cnt = 0; eop_idx = -1; eop_mod = 2'd0;
      pl_taken = 0; vld_bad = 0; mod_bad = 0; done_at = -1; err_seen = 0;
      pidx = 0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         i_start     = (cyc == 0) || (cyc == restart_at);
         i_dst_mac   = (cyc == restart_at) ? 48'hDEAD_BEEF_0000 : DST;
         i_len       = (cyc == restart_at) ? 11'd1501 : 11'(len);
         i_tx_rdy    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         i_pl_vld    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         i_pl_data   = src_word(pidx, seed, len);
         #1;
         if (o_tx_vld && !i_tx_rdy) vld_bad++;
         if (o_err) err_seen++;
         if (o_done) begin
            done_at = cyc;
            break;
         end
         if (o_tx_vld) begin
            if (cap_n < 512) cap[cap_n] = o_tx_data;
            if (o_tx_sop) begin sop_cnt++; sop_idx = cap_n; end
            if (o_tx_eop) begin eop_cnt++; eop_idx = cap_n; eop_mod = o_tx_mod; end
            else if (o_tx_mod != 2'd0) mod_bad++;
            cap_n++;
         end
         if (i_pl_vld && o_pl_rdy) begin
            pidx++;
            pl_taken++;
         end
         if (stop_words > 0 && cap_n == stop_words) break;
      end
      i_start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_start = 1'b0; i_dst_mac = DST; i_src_mac = SRC; i_ethertype = TYPE;
      i_len = 11'd46; i_pl_data = 32'h0; i_pl_vld = 1'b1; i_tx_rdy = 1'b1;
      #12;
      vectors++;
      if ({o_pl_rdy, o_tx_data, o_tx_mod, o_tx_sop, o_tx_eop, o_tx_vld, o_busy, o_done, o_err} !== 41'h0) begin
         miscompares++;
         $display("FAIL reset_outputs got vld=%b rdy=%b busy=%b done=%b err=%b data=%h want all 0",
                  o_tx_vld, o_pl_rdy, o_busy, o_done, o_err, o_tx_data);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_len46;
      int nb;
      run_frame(46, 0, 1'b0, -1, 0, 100);
      vectors++; if (cap_n != 15) begin miscompares++; $display("FAIL len46_words got %0d want 15", cap_n); end
      vectors++; if (cap[0] !== 32'h0011_2233 || cap[1] !== 32'h4455_6677 || cap[2] !== 32'h8899_AABB) begin
         miscompares++; $display("FAIL len46_header got %h %h %h want 00112233 44556677 8899aabb", cap[0], cap[1], cap[2]); end
      vectors++; if (cap[3] !== 32'h88B5_0001) begin miscompares++; $display("FAIL len46_w3 got %h want 88b50001", cap[3]); end
      vectors++; if (cap[14] !== 32'h2A2B_2C2D) begin miscompares++; $display("FAIL len46_eop_word got %h want 2a2b2c2d", cap[14]); end
      vectors++; if (eop_idx != 14 || eop_mod !== 2'd0 || eop_cnt != 1) begin
         miscompares++; $display("FAIL len46_eop got idx=%0d mod=%0d cnt=%0d want 14 0 1", eop_idx, eop_mod, eop_cnt); end
      vectors++; if (sop_idx != 0 || sop_cnt != 1 || mod_bad != 0) begin
         miscompares++; $display("FAIL len46_sop got idx=%0d cnt=%0d modbad=%0d want 0 1 0", sop_idx, sop_cnt, mod_bad); end
      vectors++; if (pl_taken != 12) begin miscompares++; $display("FAIL len46_pl_taken got %0d want 12", pl_taken); end
      vectors++; if (done_at != 16) begin miscompares++; $display("FAIL len46_done_cycle got %0d want 16", done_at); end
      nb = count_bad(0, 46);
      vectors++; if (nb != 0) begin miscompares++; $display("FAIL len46_content bad=%0d first=%0d got %h want %h",
                                       nb, first_bad, cap[first_bad], exp_word(first_bad, 0, 46)); end
      @(negedge clk); #1;
      vectors++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++; $display("FAIL len46_done_pulse got done=%b busy=%b want 0 0", o_done, o_busy); end
   endtask

   task automatic test_len1;
      int zbad;
      run_frame(1, 8'hAB, 1'b0, -1, 0, 100);
      vectors++; if (cap_n != 15) begin miscompares++; $display("FAIL len1_words got %0d want 15", cap_n); end
      vectors++; if (cap[3] !== 32'h88B5_AB00) begin miscompares++; $display("FAIL len1_w3 got %h want 88b5ab00", cap[3]); end
      zbad = 0;
      for (int k = 4; k < 15; k++) if (cap[k] !== 32'h0) zbad++;
      vectors++; if (zbad != 0) begin miscompares++; $display("FAIL len1_pad_zero got %0d nonzero words want 0", zbad); end
      vectors++; if (pl_taken != 1) begin miscompares++; $display("FAIL len1_pl_taken got %0d want 1", pl_taken); end
   endtask

   task automatic test_len0;
      run_frame(0, 0, 1'b0, -1, 0, 100);
      vectors++; if (cap[3] !== 32'h88B5_0000 || pl_taken != 0 || cap_n != 15) begin
         miscompares++; $display("FAIL len0_splice got w3=%h taken=%0d words=%0d want 88b50000 0 15", cap[3], pl_taken, cap_n); end
   endtask

   task automatic test_len47;
      run_frame(47, 0, 1'b0, -1, 0, 100);
      vectors++; if (cap_n != 16 || eop_idx != 15) begin
         miscompares++; $display("FAIL len47_words got %0d eop_idx=%0d want 16 15", cap_n, eop_idx); end
      vectors++; if (eop_mod !== 2'd3) begin miscompares++; $display("FAIL len47_mod got %0d want 3", eop_mod); end
      vectors++; if (cap[15] !== 32'h2E00_0000) begin miscompares++; $display("FAIL len47_eop_word got %h want 2e000000", cap[15]); end
      vectors++; if (pl_taken != 12) begin miscompares++; $display("FAIL len47_pl_taken got %0d want 12", pl_taken); end
   endtask

   task automatic test_len1500;
      int nb;
      run_frame(1500, 0, 1'b0, -1, 0, 600);
      vectors++; if (cap_n != 379 || eop_idx != 378) begin
         miscompares++; $display("FAIL len1500_words got %0d eop_idx=%0d want 379 378", cap_n, eop_idx); end
      vectors++; if (eop_mod !== 2'd2) begin miscompares++; $display("FAIL len1500_mod got %0d want 2", eop_mod); end
      vectors++; if (cap[378] !== 32'hDADB_0000) begin miscompares++; $display("FAIL len1500_eop_word got %h want dadb0000", cap[378]); end
      vectors++; if (pl_taken != 375) begin miscompares++; $display("FAIL len1500_pl_taken got %0d want 375", pl_taken); end
      vectors++; if (done_at != 380) begin miscompares++; $display("FAIL len1500_done_cycle got %0d want 380", done_at); end
      nb = count_bad(0, 1500);
      vectors++; if (nb != 0) begin miscompares++; $display("FAIL len1500_content bad=%0d first=%0d", nb, first_bad); end
   endtask

   task automatic test_stall;
      int nb;
      run_frame(47, 8'h40, 1'b1, -1, 0, 2000);
      vectors++; if (done_at < 0) begin miscompares++; $display("FAIL stall_timeout got no done want done within 2000 cycles"); end
      vectors++; if (vld_bad != 0) begin miscompares++; $display("FAIL stall_vld_without_rdy got %0d want 0", vld_bad); end
      vectors++; if (cap_n != 16 || eop_mod !== 2'd3 || pl_taken != 12) begin
         miscompares++; $display("FAIL stall_geometry got words=%0d mod=%0d taken=%0d want 16 3 12", cap_n, eop_mod, pl_taken); end
      nb = count_bad(8'h40, 47);
      vectors++; if (nb != 0) begin miscompares++; $display("FAIL stall_content bad=%0d first=%0d", nb, first_bad); end
   endtask

   task automatic test_err;
      int errs, err_cyc, busys, vlds;
      errs = 0; err_cyc = -1; busys = 0; vlds = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         i_start  = (cyc == 0);
         i_len    = 11'd1501;
         i_tx_rdy = 1'b1;
         i_pl_vld = 1'b1;
         #1;
         if (o_err) begin errs++; err_cyc = cyc; end
         if (o_busy) busys++;
         if (o_tx_vld) vlds++;
      end
      i_start = 1'b0;
      vectors++; if (errs != 1 || err_cyc != 1) begin
         miscompares++; $display("FAIL err_pulse got count=%0d cycle=%0d want 1 1", errs, err_cyc); end
      vectors++; if (busys != 0) begin miscompares++; $display("FAIL err_busy got %0d busy cycles want 0", busys); end
      vectors++; if (vlds != 0) begin miscompares++; $display("FAIL err_vld got %0d vld cycles want 0", vlds); end
   endtask

   task automatic test_busy_start;
      int nb, idle_act;
      run_frame(46, 8'h10, 1'b0, 5, 0, 100);
      nb = count_bad(8'h10, 46);
      vectors++; if (nb != 0 || cap_n != 15) begin
         miscompares++; $display("FAIL busy_start_content bad=%0d words=%0d want 0 15", nb, cap_n); end
      vectors++; if (err_seen != 0 || done_at != 16) begin
         miscompares++; $display("FAIL busy_start_ignored got err=%0d done_at=%0d want 0 16", err_seen, done_at); end
      idle_act = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk); #1;
         if (o_busy || o_tx_vld || o_err) idle_act++;
      end
      vectors++; if (idle_act != 0) begin miscompares++; $display("FAIL busy_start_after got %0d active cycles want 0", idle_act); end
   endtask

   task automatic test_reset_mid;
      int nb;
      run_frame(46, 0, 1'b0, -1, 7, 100);
      vectors++; if (cap_n != 7 || o_busy !== 1'b1) begin
         miscompares++; $display("FAIL midrst_setup got words=%0d busy=%b want 7 1", cap_n, o_busy); end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_pl_rdy, o_tx_data, o_tx_mod, o_tx_sop, o_tx_eop, o_tx_vld, o_busy, o_done, o_err} !== 41'h0) begin
         miscompares++;
         $display("FAIL midrst_outputs got vld=%b rdy=%b busy=%b eop=%b data=%h want all 0",
                  o_tx_vld, o_pl_rdy, o_busy, o_tx_eop, o_tx_data);
      end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      run_frame(48, 8'h20, 1'b0, -1, 0, 100);
      nb = count_bad(8'h20, 48);
      vectors++; if (sop_idx != 0 || sop_cnt != 1 || cap_n != 16 || nb != 0) begin
         miscompares++; $display("FAIL midrst_recover got sop_idx=%0d sops=%0d words=%0d bad=%0d want 0 1 16 0",
                                 sop_idx, sop_cnt, cap_n, nb); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset;
      test_len46;
      test_len1;
      test_len0;
      test_len47;
      test_len1500;
      test_stall;
      test_err;
      test_busy_start;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
